// File: rtl/fpu_issue_scoreboard.sv
// fpu_issue_scoreboard: FPU issue hazard scoreboard with one writeback slot per future cycle; define FPU_DIV_PIPE_EN for a fully pipelined div/sqrt unit
module fpu_issue_scoreboard #(
  parameter int NREG = 32,
  parameter int MAX_LAT = 16,
  parameter int LAT_ADD = 3,
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 10,
  parameter int LAT_SQRT = 7,
  parameter int LAT_MISC = 1,
  localparam int RW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [4:0]      issue_op,
  input  logic [RW-1:0]   issue_rd,
  input  logic [RW-1:0]   issue_rs1,
  input  logic [RW-1:0]   issue_rs2,
  input  logic            issue_rs2_used,
  input  logic            flush,
  output logic            wb_valid,
  output logic [RW-1:0]   wb_rd,
  output logic [NREG-1:0] pending,
  output logic            div_busy
);
  localparam int LW = $clog2(MAX_LAT + 1);
  localparam logic [4:0] OP_ADD = 5'b10000;
  localparam logic [4:0] OP_SUB = 5'b10001;
  localparam logic [4:0] OP_MUL = 5'b10010;
  localparam logic [4:0] OP_DIV = 5'b10011;
  localparam logic [4:0] OP_SQRT = 5'b10100;
  logic [LW-1:0] lat;
  logic [MAX_LAT:1] slot_v, nv;
  logic [MAX_LAT+1:1] sv_ext;
  logic [RW-1:0] slot_rd [1:MAX_LAT];
  logic [RW-1:0] nrd [1:MAX_LAT];
  logic [NREG-1:0] set_m, clr_m;
  logic hz_raw, hz_waw, hz_wb, hz_div, accept;
  always_comb
    lat = (issue_op == OP_ADD || issue_op == OP_SUB) ? LW'(LAT_ADD) :
          (issue_op == OP_MUL) ? LW'(LAT_MUL) :
          (issue_op == OP_DIV) ? LW'(LAT_DIV) :
          (issue_op == OP_SQRT) ? LW'(LAT_SQRT) : LW'(LAT_MISC);
  // slot[L+1] is the entry that lands in slot[L] after this cycle's shift
  assign sv_ext = {1'b0, slot_v};
  assign hz_wb = sv_ext[lat + LW'(1)];
  assign hz_raw = pending[issue_rs1] | (pending[issue_rs2] & issue_rs2_used);
  assign hz_waw = pending[issue_rd];
  assign issue_ready = !hz_raw & !hz_waw & !hz_wb & !hz_div & !flush;
  assign accept = issue_valid & issue_ready;
  assign wb_valid = slot_v[1];
  assign wb_rd = slot_rd[1];
  assign set_m = accept ? (NREG'(1) << issue_rd) : '0;
  assign clr_m = wb_valid ? (NREG'(1) << wb_rd) : '0;
  always_comb begin
    nv = {1'b0, slot_v[MAX_LAT:2]};
    for (int k = 1; k < MAX_LAT; k++) nrd[k] = slot_rd[k+1];
    nrd[MAX_LAT] = '0;
    if (accept) begin
      nv[lat] = 1'b1;
      nrd[lat] = issue_rd;
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn || flush) begin
      slot_v <= '0;
      slot_rd <= '{default: '0};
      pending <= '0;
    end else begin
      slot_v <= nv;
      slot_rd <= nrd;
      pending <= (pending & ~clr_m) | set_m;
    end
`ifdef FPU_DIV_PIPE_EN
  assign hz_div = 1'b0;
  assign div_busy = 1'b0;
`else
  logic [LW-1:0] div_cnt;
  assign div_busy = div_cnt != '0;
  assign hz_div = (issue_op == OP_DIV || issue_op == OP_SQRT) && div_busy;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) div_cnt <= '0;
    else if (flush) div_cnt <= '0;
    else if (accept && (issue_op == OP_DIV || issue_op == OP_SQRT)) div_cnt <= lat - LW'(1);
    else if (div_busy) div_cnt <= div_cnt - LW'(1);
`endif
endmodule
